// File: rtl/div_sequencer_if.sv
// Request/response bundle between the EX-stage issue logic and the iterative divider.
interface div_sequencer_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            start;
  logic [1:0]      opcode;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            stall_req;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output flush, start, opcode, dividend, divisor,
    input  stall_req, busy, done, result
  );

  modport slave (
    input  flush, start, opcode, dividend, divisor,
    output stall_req, busy, done, result
  );
endinterface

// File: rtl/div_sequencer.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU.
// Produces one quotient bit per cycle, then applies sign fix-up.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst,
  div_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [5:0]      CNT_INIT = 6'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_t          r_state, w_next;
  logic [5:0]      r_cnt;
  logic [XLEN-1:0] r_quo, r_rem, r_dvs, r_result;
  logic            r_neg_q, r_neg_r, r_is_rem;

  logic            w_signed, w_div0, w_ovf, w_accept;
  logic            w_busy, w_done, w_ge;
  logic [XLEN:0]   w_shift, w_diff;
  logic signed [XLEN-1:0] w_dvd_s, w_dvs_s;

  function automatic logic [XLEN-1:0] f_mag(input logic signed [XLEN-1:0] v,
                                            input logic sgn);
    return (sgn && v[XLEN-1]) ? XLEN'(-v) : XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] f_apply_sign(input logic [XLEN-1:0] v,
                                                   input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign w_dvd_s  = signed'(bus.dividend);
  assign w_dvs_s  = signed'(bus.divisor);
  assign w_signed = ~bus.opcode[0];
  assign w_div0   = (bus.divisor == '0);
  assign w_ovf    = w_signed && (bus.dividend == INT_MIN) && (bus.divisor == '1);
  assign w_accept = (r_state == S_IDLE) && bus.start && !bus.flush;

  // One restoring step: shift in next dividend bit, keep the difference if no borrow.
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_ge    = ~w_diff[XLEN];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (w_div0 || w_ovf) ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == '0) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (bus.flush) w_next = S_IDLE;
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_CALC, S_FIX: w_busy = 1'b1;
      S_DONE:        w_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.stall_req = bus.start & ~w_done & ~bus.flush;
  assign bus.result    = r_result;

  // Datapath: operands are captured once in IDLE; result is written only on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_result <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_rem <= 1'b0;
    end else if (!bus.flush) begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_is_rem <= bus.opcode[1];
          if (w_div0) begin
            r_result <= bus.opcode[1] ? bus.dividend : '1;
          end else if (w_ovf) begin
            r_result <= bus.opcode[1] ? '0 : bus.dividend;
          end else begin
            r_quo   <= f_mag(w_dvd_s, w_signed);
            r_dvs   <= f_mag(w_dvs_s, w_signed);
            r_rem   <= '0;
            r_cnt   <= CNT_INIT;
            r_neg_q <= w_signed && (bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1]);
            r_neg_r <= w_signed && bus.dividend[XLEN-1];
          end
        end
        S_CALC: begin
          r_rem <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
          r_quo <= {r_quo[XLEN-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          r_result <= r_is_rem ? f_apply_sign(r_rem, r_neg_r)
                               : f_apply_sign(r_quo, r_neg_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: latency, stall, results, flush and reset behaviour.
module tb_div_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  div_sequencer_if #(.XLEN(32)) bus ();

  div_sequencer #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one instruction in the current cycle and follows it to completion.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] exp_res,
                        input bit scramble);
    int          lat;
    int          stall_bad;
    logic [31:0] res;
    lat       = -1;
    stall_bad = 0;
    res       = '0;
    bus.start    = 1'b1;
    bus.opcode   = op;
    bus.dividend = a;
    bus.divisor  = b;
    #1;
    if (bus.stall_req !== 1'b1) stall_bad++;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (scramble && k == 3) begin
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        bus.opcode   = 2'($urandom);
        #1;
      end
      if (bus.done === 1'b1) begin
        lat = k;
        res = bus.result;
        if (bus.stall_req !== 1'b0) stall_bad++;
        break;
      end
      if (bus.stall_req !== 1'b1) stall_bad++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, res, exp_res);
    chk({tag, "_stall"}, 32'(stall_bad), 32'd0);
    tick();
    bus.start = 1'b0;
    #1;
    chk({tag, "_hold"}, bus.result, exp_res);
    chk({tag, "_idle"}, {30'd0, bus.busy, bus.done}, 32'd0);
  endtask

  int ndone;

  initial begin
    rst          = 1'b1;
    bus.flush    = 1'b0;
    bus.start    = 1'b0;
    bus.opcode   = 2'b00;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) tick();
    chk("rst_busy",   {31'd0, bus.busy},      32'd0);
    chk("rst_done",   {31'd0, bus.done},      32'd0);
    chk("rst_result", bus.result,             32'd0);
    chk("rst_stall",  {31'd0, bus.stall_req}, 32'd0);
    rst = 1'b0;
    tick();

    run_op("divu_100_7",  2'b01, 32'd100, 32'd7, 34, 32'd14, 1'b0);
    run_op("remu_100_7",  2'b11, 32'd100, 32'd7, 34, 32'd2,  1'b0);
    run_op("div_m7_2",    2'b00, 32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFD, 1'b0);
    run_op("rem_m7_2",    2'b10, 32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFF, 1'b0);
    run_op("rem_7_m2",    2'b10, 32'd7, 32'hFFFFFFFE, 34, 32'd1, 1'b0);
    run_op("divu_5_0",    2'b01, 32'd5, 32'd0, 1, 32'hFFFFFFFF, 1'b0);
    run_op("remu_5_0",    2'b11, 32'd5, 32'd0, 1, 32'd5, 1'b0);
    run_op("div_ovf",     2'b00, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 1'b0);
    run_op("rem_ovf",     2'b10, 32'h80000000, 32'hFFFFFFFF, 1, 32'd0, 1'b0);
    run_op("divu_big",    2'b01, 32'hFFFFFFFF, 32'd16, 34, 32'h0FFFFFFF, 1'b0);

    // Flush ten cycles into a long divide, then issue a fresh one.
    ndone        = 0;
    bus.start    = 1'b1;
    bus.opcode   = 2'b01;
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd3;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (bus.done === 1'b1) ndone++;
    end
    bus.flush = 1'b1;
    #1;
    chk("flush_stall", {31'd0, bus.stall_req}, 32'd0);
    tick();
    bus.flush = 1'b0;
    bus.start = 1'b0;
    #1;
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    chk("flush_done", {31'd0, bus.done}, 32'd0);
    tick();
    chk("flush_nodone", 32'(ndone), 32'd0);
    run_op("flush_divu_9_3", 2'b01, 32'd9, 32'd3, 34, 32'd3, 1'b0);

    // Reset mid-operation with start still asserted.
    bus.start    = 1'b1;
    bus.opcode   = 2'b01;
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    #1;
    chk("midrst_busy",   {31'd0, bus.busy}, 32'd0);
    chk("midrst_done",   {31'd0, bus.done}, 32'd0);
    chk("midrst_result", bus.result,        32'd0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.done === 1'b1) ndone++;
    end
    chk("midrst_nodone", 32'(ndone), 32'd0);

    // Operand changes during CALC must not disturb the latched operation.
    run_op("scr_divu", 2'b01, 32'd100, 32'd7, 34, 32'd14, 1'b1);
    run_op("scr_remu", 2'b11, 32'd100, 32'd7, 34, 32'd2,  1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
